// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: opcodes, funct3 values,
// ALU operation codes, FSM state type and the per-stage control bundle.
package pipe_ctrl_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_PASS = 4'd10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_PC4 = 2'b01;
    localparam logic [1:0] WB_MEM = 2'b10;

    localparam logic [1:0] PC_SEQ  = 2'b00;
    localparam logic [1:0] PC_BR   = 2'b01;
    localparam logic [1:0] PC_JALR = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    // One instruction's worth of control, carried ID/EX -> EX/MEM -> MEM/WB.
    // rd is only non-zero when the instruction really writes the register file.
    typedef struct packed {
        logic [3:0] alufn;
        logic       alusrc;
        logic       asel_pc;
        logic       mem_read;
        logic       mem_write;
        logic [2:0] funct3;
        logic       regwrite;
        logic [1:0] wb_src;
        logic [4:0] rd;
        logic       is_branch;
        logic       is_jal;
        logic       is_jalr;
        logic       is_system;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    // Branch condition from the SUB flags; cf=1 means no borrow.
    function automatic logic branch_taken(input logic [2:0] f3, input logic cf,
                                          input logic zf, input logic vf, input logic sf);
        case (f3)
            F3_BEQ:  return zf;
            F3_BNE:  return !zf;
            F3_BLT:  return sf != vf;
            F3_BGE:  return sf == vf;
            F3_BLTU: return !cf;
            F3_BGEU: return cf;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle between the datapath (master) and the pipeline controller (slave).
interface pipe_ctrl_if #(
    parameter int ALUFN_W = 4
);
    logic [31:0]        id_ir;
    logic               id_valid;
    logic               ex_cf;
    logic               ex_zf;
    logic               ex_vf;
    logic               ex_sf;
    logic [ALUFN_W-1:0] ex_alufn;
    logic               ex_alusrc;
    logic               ex_asel_pc;
    logic               mem_read;
    logic               mem_write;
    logic [2:0]         mem_size;
    logic               wb_regwrite;
    logic [1:0]         wb_src;
    logic [4:0]         wb_rd;
    logic [1:0]         pc_sel;
    logic               stall;
    logic               flush;
    logic               halted;

    modport master (
        output id_ir, id_valid, ex_cf, ex_zf, ex_vf, ex_sf,
        input  ex_alufn, ex_alusrc, ex_asel_pc, mem_read, mem_write, mem_size,
        input  wb_regwrite, wb_src, wb_rd, pc_sel, stall, flush, halted
    );

    modport slave (
        input  id_ir, id_valid, ex_cf, ex_zf, ex_vf, ex_sf,
        output ex_alufn, ex_alusrc, ex_asel_pc, mem_read, mem_write, mem_size,
        output wb_regwrite, wb_src, wb_rd, pc_sel, stall, flush, halted
    );
endinterface

// File: rtl/pipe_ctrl_decode.sv
// Purely combinational RV32I decode of the instruction in ID into a control
// bundle, plus which source registers it actually reads.
module ctrl_decode
    import pipe_ctrl_pkg::*;
#(
    parameter bit HALT_ON_SYSTEM = 1'b1
) (
    input  logic [31:0]     ir,
    output ctrl_t           ctrl,
    output logic            known,
    output logic [1:0]      uses_rs,
    output logic [1:0][4:0] rs_idx
);
    logic [6:0] opcode;
    logic [2:0] f3;
    logic [4:0] rd;
    logic       alt;
    logic       writes;
    logic       unused_bits;

    assign opcode      = ir[6:0];
    assign rd          = ir[11:7];
    assign f3          = ir[14:12];
    assign alt         = ir[30];
    assign rs_idx[0]   = ir[19:15];
    assign rs_idx[1]   = ir[24:20];
    assign unused_bits = ^{ir[31], ir[29:25]};

    // SUB only exists in R-type; SRA/SRAI share the funct7[5] select.
    function automatic logic [3:0] arith_fn(input logic [2:0] f, input logic a, input logic is_reg);
        case (f)
            F3_ADD:  return (is_reg && a) ? ALU_SUB : ALU_ADD;
            F3_SLL:  return ALU_SLL;
            F3_SLT:  return ALU_SLT;
            F3_SLTU: return ALU_SLTU;
            F3_XOR:  return ALU_XOR;
            F3_SR:   return a ? ALU_SRA : ALU_SRL;
            F3_OR:   return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // Opcode decode; uses_rs bit 0 is rs1, bit 1 is rs2.
    always_comb begin
        ctrl    = CTRL_BUBBLE;
        known   = 1'b1;
        writes  = 1'b0;
        uses_rs = 2'b00;
        case (opcode)
            OP_LUI: begin
                ctrl.alufn  = ALU_PASS;
                ctrl.alusrc = 1'b1;
                writes      = 1'b1;
            end
            OP_AUIPC: begin
                ctrl.alufn   = ALU_ADD;
                ctrl.alusrc  = 1'b1;
                ctrl.asel_pc = 1'b1;
                writes       = 1'b1;
            end
            OP_JAL: begin
                ctrl.is_jal = 1'b1;
                ctrl.wb_src = WB_PC4;
                writes      = 1'b1;
            end
            OP_JALR: begin
                ctrl.is_jalr = 1'b1;
                ctrl.alusrc  = 1'b1;
                ctrl.wb_src  = WB_PC4;
                writes       = 1'b1;
                uses_rs      = 2'b01;
            end
            OP_BRANCH: begin
                ctrl.alufn     = ALU_SUB;
                ctrl.is_branch = 1'b1;
                ctrl.funct3    = f3;
                uses_rs        = 2'b11;
            end
            OP_LOAD: begin
                ctrl.alusrc   = 1'b1;
                ctrl.mem_read = 1'b1;
                ctrl.funct3   = f3;
                ctrl.wb_src   = WB_MEM;
                writes        = 1'b1;
                uses_rs       = 2'b01;
            end
            OP_STORE: begin
                ctrl.alusrc    = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.funct3    = f3;
                uses_rs        = 2'b11;
            end
            OP_IMM: begin
                ctrl.alufn  = arith_fn(f3, alt, 1'b0);
                ctrl.alusrc = 1'b1;
                writes      = 1'b1;
                uses_rs     = 2'b01;
            end
            OP_REG: begin
                ctrl.alufn = arith_fn(f3, alt, 1'b1);
                writes     = 1'b1;
                uses_rs    = 2'b11;
            end
            OP_FENCE, OP_SYSTEM: begin
                ctrl.is_system = HALT_ON_SYSTEM;
            end
            default: known = 1'b0;
        endcase
        ctrl.regwrite = writes && (rd != 5'd0);
        ctrl.rd       = ctrl.regwrite ? rd : 5'd0;
    end
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: ID/EX, EX/MEM, MEM/WB control registers, load-use and
// control-flow hazard handling, and the RUN/STALL/HALT state machine.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int ALUFN_W        = 4,
    parameter bit HALT_ON_SYSTEM = 1'b1
) (
    input  logic      clk,
    input  logic      rst_n,
    pipe_ctrl_if.slave bus
);
    localparam int NSTAGE = 3;

    ctrl_t           stage_reg [NSTAGE];
    ctrl_t           idex_next;
    ctrl_t           ex_c, mem_c, wb_c;
    state_t          state_reg, state_next;
    ctrl_t           dec_ctrl;
    logic            dec_known;
    logic [1:0]      dec_uses_rs;
    logic [1:0][4:0] dec_rs_idx;
    logic [1:0]      rs_hit;
    logic            br_taken, redirect_pc, redirect_reg, flush_c;
    logic            load_use, halt_req, stall_c, bubble_c;
    logic            unused_ctrl;

    ctrl_decode #(.HALT_ON_SYSTEM(HALT_ON_SYSTEM)) u_decode (
        .ir      (bus.id_ir),
        .ctrl    (dec_ctrl),
        .known   (dec_known),
        .uses_rs (dec_uses_rs),
        .rs_idx  (dec_rs_idx)
    );

    assign ex_c        = stage_reg[0];
    assign mem_c       = stage_reg[1];
    assign wb_c        = stage_reg[2];
    assign unused_ctrl = ^{mem_c, wb_c};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rs_hit
            assign rs_hit[gi] = dec_uses_rs[gi] && (dec_rs_idx[gi] == ex_c.rd);
        end
    endgenerate

    // A load in EX with a real rd whose value the ID instruction needs.
    assign load_use = ex_c.mem_read && (ex_c.rd != 5'd0) && bus.id_valid && (|rs_hit);

    // Branch/jump resolution in EX straight off this cycle's ALU flags.
    assign br_taken     = ex_c.is_branch &&
                          branch_taken(ex_c.funct3, bus.ex_cf, bus.ex_zf, bus.ex_vf, bus.ex_sf);
    assign redirect_pc  = ex_c.is_jal || br_taken;
    assign redirect_reg = ex_c.is_jalr;
    assign flush_c      = redirect_pc || redirect_reg;
    assign halt_req     = ex_c.is_system;

    // Next state and hazard outputs; flush wins over a same-cycle load-use.
    always_comb begin
        state_next = state_reg;
        stall_c    = 1'b0;
        case (state_reg)
            ST_RUN: begin
                if (flush_c) begin
                    state_next = ST_RUN;
                end else if (load_use) begin
                    state_next = ST_STALL;
                    stall_c    = 1'b1;
                end else if (halt_req) begin
                    state_next = ST_HALT;
                end
            end
            ST_STALL: state_next = ST_RUN;
            ST_HALT:  stall_c    = 1'b1;
            default:  state_next = ST_RUN;
        endcase
        // Nothing behind a halting instruction is allowed to issue.
        bubble_c  = !bus.id_valid || !dec_known || stall_c || flush_c || halt_req ||
                    (state_reg == ST_HALT);
        idex_next = bubble_c ? CTRL_BUBBLE : dec_ctrl;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= ST_RUN;
        else        state_reg <= state_next;
    end

    // Control bundle advances one stage per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NSTAGE; i++) stage_reg[i] <= CTRL_BUBBLE;
        end else begin
            stage_reg[0] <= idex_next;
            for (int i = 1; i < NSTAGE; i++) stage_reg[i] <= stage_reg[i-1];
        end
    end

    assign bus.ex_alufn    = ALUFN_W'(ex_c.alufn);
    assign bus.ex_alusrc   = ex_c.alusrc;
    assign bus.ex_asel_pc  = ex_c.asel_pc;
    assign bus.mem_read    = mem_c.mem_read;
    assign bus.mem_write   = mem_c.mem_write;
    assign bus.mem_size    = (mem_c.mem_read || mem_c.mem_write) ? mem_c.funct3 : 3'd0;
    assign bus.wb_regwrite = wb_c.regwrite;
    assign bus.wb_src      = wb_c.wb_src;
    assign bus.wb_rd       = wb_c.rd;
    assign bus.pc_sel      = redirect_reg ? PC_JALR : (redirect_pc ? PC_BR : PC_SEQ);
    assign bus.flush       = flush_c;
    assign bus.stall       = stall_c;
    assign bus.halted      = (state_reg == ST_HALT);
endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized bench for pipe_ctrl against an instruction-level pipeline model.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_ctrl_if #(.ALUFN_W(4)) bus ();

    pipe_ctrl #(.ALUFN_W(4), .HALT_ON_SYSTEM(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic        v;
        logic [31:0] ir;
    } slot_t;

    int          n_total = 0;
    int          n_bad = 0;
    slot_t       ex_s, mem_s, wb_s;
    logic        m_halted;
    int          halt_cycles;
    logic [31:0] id_ir_q;
    logic        id_v_q;
    logic [31:0] dir_q[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] rd, input logic [2:0] f3,
                                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [6:0] f7);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    function automatic logic is_known(input logic [31:0] ir);
        case (ir[6:0])
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE,
            OP_IMM, OP_REG, OP_FENCE, OP_SYSTEM: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic reads_rs1(input logic [31:0] ir);
        case (ir[6:0])
            OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic reads_rs2(input logic [31:0] ir);
        return ir[6:0] == OP_BRANCH || ir[6:0] == OP_STORE || ir[6:0] == OP_REG;
    endfunction

    function automatic logic writes_rd(input logic [31:0] ir);
        case (ir[6:0])
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_IMM, OP_REG: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] arith(input logic [2:0] f3, input logic b30, input logic is_reg);
        case (f3)
            3'd0: return (is_reg && b30) ? ALU_SUB : ALU_ADD;
            3'd1: return ALU_SLL;
            3'd2: return ALU_SLT;
            3'd3: return ALU_SLTU;
            3'd4: return ALU_XOR;
            3'd5: return b30 ? ALU_SRA : ALU_SRL;
            3'd6: return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic logic [3:0] exp_alu(input slot_t s);
        if (!s.v) return 4'd0;
        case (s.ir[6:0])
            OP_LUI: return ALU_PASS;
            OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_STORE: return ALU_ADD;
            OP_BRANCH: return ALU_SUB;
            OP_IMM: return arith(s.ir[14:12], s.ir[30], 1'b0);
            OP_REG: return arith(s.ir[14:12], s.ir[30], 1'b1);
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic br_cond(input logic [2:0] f3, input logic cf, input logic zf,
                                     input logic vf, input logic sf);
        case (f3)
            3'd0: return zf;
            3'd1: return !zf;
            3'd4: return sf ^ vf;
            3'd5: return !(sf ^ vf);
            3'd6: return !cf;
            3'd7: return cf;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] rand_ir();
        int k;
        logic [4:0] rd, r1, r2;
        logic [2:0] f3;
        k  = $urandom_range(0, 99);
        rd = 5'($urandom_range(0, 3));
        r1 = 5'($urandom_range(0, 3));
        r2 = 5'($urandom_range(0, 3));
        f3 = 3'($urandom);
        if (k < 20) return enc(OP_REG, rd, f3, r1, r2, ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00);
        if (k < 40) return enc(OP_IMM, rd, f3, r1, r2, 7'($urandom));
        if (k < 48) return enc(OP_LOAD, rd, f3, r1, r2, 7'h00);
        if (k < 56) return enc(OP_STORE, rd, f3, r1, r2, 7'h00);
        if (k < 66) return enc(OP_BRANCH, rd, f3, r1, r2, 7'h00);
        if (k < 70) return enc(OP_JAL, rd, f3, r1, r2, 7'h00);
        if (k < 74) return enc(OP_JALR, rd, 3'd0, r1, r2, 7'h00);
        if (k < 78) return enc(OP_LUI, rd, f3, r1, r2, 7'h12);
        if (k < 82) return enc(OP_AUIPC, rd, f3, r1, r2, 7'h34);
        if (k < 88) return enc(7'b1111111, rd, f3, r1, r2, 7'h00);
        if (k < 98) return enc(OP_REG, rd, 3'd0, r1, r2, 7'h20);
        if (k == 98) return enc(OP_SYSTEM, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00);
        return enc(OP_FENCE, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00);
    endfunction

    task automatic model_clear();
        ex_s = '0;
        mem_s = '0;
        wb_s = '0;
        m_halted = 1'b0;
        halt_cycles = 0;
        id_v_q = 1'b0;
        id_ir_q = 32'h0;
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        #1;
        check_val("rst_alufn", 32'(bus.ex_alufn), 32'd0);
        check_val("rst_alusrc", 32'(bus.ex_alusrc), 32'd0);
        check_val("rst_asel", 32'(bus.ex_asel_pc), 32'd0);
        check_val("rst_mem_rw", 32'({bus.mem_read, bus.mem_write}), 32'd0);
        check_val("rst_mem_size", 32'(bus.mem_size), 32'd0);
        check_val("rst_wb", 32'({bus.wb_regwrite, bus.wb_src, bus.wb_rd}), 32'd0);
        check_val("rst_pc_sel", 32'(bus.pc_sel), 32'd0);
        check_val("rst_hazard", 32'({bus.stall, bus.flush}), 32'd0);
        check_val("rst_halted", 32'(bus.halted), 32'd0);
        model_clear();
        bus.id_valid = 1'b0;
        repeat (cycles) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic cycle_step(input int cyc);
        logic cf, zf, vf, sf;
        logic e_jalr, e_taken, e_flush, e_lu, e_sys, e_stall, e_we, issue;
        logic [1:0] e_pcsel, e_wbsrc;
        logic [6:0] xop, mop, wop;
        logic [4:0] xrd, r1, r2;
        bus.id_ir = id_ir_q;
        bus.id_valid = id_v_q;
        {cf, zf, vf, sf} = 4'($urandom);
        {bus.ex_cf, bus.ex_zf, bus.ex_vf, bus.ex_sf} = {cf, zf, vf, sf};
        #1;
        xop = ex_s.ir[6:0];
        mop = mem_s.ir[6:0];
        wop = wb_s.ir[6:0];
        xrd = ex_s.ir[11:7];
        r1 = id_ir_q[19:15];
        r2 = id_ir_q[24:20];
        e_jalr  = ex_s.v && xop == OP_JALR;
        e_taken = ex_s.v && (xop == OP_JAL || (xop == OP_BRANCH && br_cond(ex_s.ir[14:12], cf, zf, vf, sf)));
        e_flush = e_taken || e_jalr;
        e_pcsel = e_jalr ? 2'd2 : (e_taken ? 2'd1 : 2'd0);
        e_lu    = !e_flush && ex_s.v && xop == OP_LOAD && xrd != 5'd0 && id_v_q &&
                  ((reads_rs1(id_ir_q) && r1 == xrd) || (reads_rs2(id_ir_q) && r2 == xrd));
        e_sys   = ex_s.v && (xop == OP_SYSTEM || xop == OP_FENCE);
        e_stall = m_halted || e_lu;
        e_we    = wb_s.v && writes_rd(wb_s.ir) && wb_s.ir[11:7] != 5'd0;
        e_wbsrc = !wb_s.v ? 2'd0 : ((wop == OP_JAL || wop == OP_JALR) ? 2'd1 : (wop == OP_LOAD ? 2'd2 : 2'd0));

        check_val("ex_alufn", 32'(bus.ex_alufn), 32'(exp_alu(ex_s)));
        check_val("ex_alusrc", 32'(bus.ex_alusrc),
                  32'(ex_s.v && (xop == OP_LUI || xop == OP_AUIPC || xop == OP_JALR ||
                                 xop == OP_LOAD || xop == OP_STORE || xop == OP_IMM)));
        check_val("ex_asel_pc", 32'(bus.ex_asel_pc), 32'(ex_s.v && xop == OP_AUIPC));
        check_val("mem_read", 32'(bus.mem_read), 32'(mem_s.v && mop == OP_LOAD));
        check_val("mem_write", 32'(bus.mem_write), 32'(mem_s.v && mop == OP_STORE));
        check_val("mem_size", 32'(bus.mem_size),
                  (mem_s.v && (mop == OP_LOAD || mop == OP_STORE)) ? 32'(mem_s.ir[14:12]) : 32'd0);
        check_val("wb_regwrite", 32'(bus.wb_regwrite), 32'(e_we));
        check_val("wb_src", 32'(bus.wb_src), 32'(e_wbsrc));
        check_val("wb_rd", 32'(bus.wb_rd), e_we ? 32'(wb_s.ir[11:7]) : 32'd0);
        check_val("pc_sel", 32'(bus.pc_sel), 32'(e_pcsel));
        check_val("flush", 32'(bus.flush), 32'(e_flush));
        check_val("stall", 32'(bus.stall), 32'(e_stall));
        check_val("halted", 32'(bus.halted), 32'(m_halted));
        $display("cyc=%0d id=%h v=%0d ex=%h/%0d stall=%0d flush=%0d pc_sel=%0d halted=%0d wb_we=%0d wb_rd=%0d",
                 cyc, id_ir_q, id_v_q, ex_s.ir, ex_s.v, bus.stall, bus.flush, bus.pc_sel,
                 bus.halted, bus.wb_regwrite, bus.wb_rd);

        issue = id_v_q && is_known(id_ir_q) && !m_halted && !e_flush && !e_lu && !e_sys;
        wb_s = mem_s;
        mem_s = ex_s;
        ex_s.v = issue;
        ex_s.ir = id_ir_q;
        if (e_sys) m_halted = 1'b1;
        if (m_halted) halt_cycles++;

        if (e_flush) begin
            id_v_q = 1'b0;
            id_ir_q = rand_ir();
        end else if (!e_stall) begin
            if (dir_q.size() > 0) begin
                id_ir_q = dir_q.pop_front();
                id_v_q = 1'b1;
            end else begin
                id_ir_q = rand_ir();
                id_v_q = ($urandom_range(0, 9) != 0);
            end
        end
    endtask

    initial begin
        bus.id_ir = 32'h0;
        bus.id_valid = 1'b0;
        {bus.ex_cf, bus.ex_zf, bus.ex_vf, bus.ex_sf} = 4'h0;
        model_clear();
        #2;
        do_reset(2);

        dir_q.push_back(enc(OP_IMM, 5'd1, 3'd0, 5'd0, 5'd5, 7'h00));    // ADDI x1,x0,5
        dir_q.push_back(enc(OP_LOAD, 5'd2, 3'd2, 5'd1, 5'd0, 7'h00));   // LW x2,0(x1)
        dir_q.push_back(enc(OP_REG, 5'd3, 3'd0, 5'd2, 5'd2, 7'h00));    // ADD x3,x2,x2
        dir_q.push_back(enc(OP_REG, 5'd0, 3'd0, 5'd1, 5'd2, 7'h00));    // ADD x0,x1,x2
        dir_q.push_back(enc(OP_IMM, 5'd1, 3'd5, 5'd1, 5'd3, 7'h20));    // SRAI x1,x1,3
        dir_q.push_back(enc(OP_BRANCH, 5'd8, 3'd0, 5'd1, 5'd2, 7'h00)); // BEQ x1,x2
        dir_q.push_back(enc(OP_LOAD, 5'd3, 3'd0, 5'd1, 5'd0, 7'h00));   // LB x3,0(x1)
        dir_q.push_back(enc(OP_BRANCH, 5'd8, 3'd6, 5'd3, 5'd1, 7'h00)); // BLTU x3,x1
        dir_q.push_back(enc(OP_STORE, 5'd4, 3'd2, 5'd1, 5'd3, 7'h00));  // SW x3,4(x1)
        dir_q.push_back(enc(OP_SYSTEM, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00)); // ECALL

        for (int cyc = 0; cyc < 900; cyc++) begin
            @(negedge clk);
            cycle_step(cyc);
            if (m_halted && halt_cycles >= 25) do_reset(2);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter ALUFN_W, default 4: width of the ALU function code.
REQ-002 Parameter HALT_ON_SYSTEM, default 1: ECALL/EBREAK/FENCE halt the core when 1; they decode as NOP when 0.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 id_ir  in  32  instruction held in IF/ID.
REQ-006 id_valid  in  1  id_ir holds a real instruction.
REQ-007 ex_cf, ex_zf, ex_vf, ex_sf  in  1 each  ALU flags of the instruction currently in EX, same cycle.
REQ-008 ex_alufn  out  ALUFN_W  ALU operation for EX.
REQ-009 ex_alusrc  out  1  1 selects immediate as ALU operand B.
REQ-010 ex_asel_pc  out  1  1 selects PC as ALU operand A (AUIPC).
REQ-011 mem_read, mem_write  out  1 each  data-memory strobes for the MEM stage.
REQ-012 mem_size  out  3  funct3 of the load/store in MEM.
REQ-013 wb_regwrite  out  1  register-file write enable for WB.
REQ-014 wb_src  out  2  write-back source: 00 ALU, 01 PC+4, 10 memory.
REQ-015 wb_rd  out  5  destination register for WB.
REQ-016 pc_sel  out  2  next-PC source: 00 PC+4, 01 branch/JAL target, 10 JALR target.
REQ-017 stall  out  1  hold PC and IF/ID.
REQ-018 flush  out  1  invalidate IF/ID.
REQ-019 halted  out  1  core is in the HALT state.

Function
REQ-020 Decode all RV32I opcodes in ID, including full Arith_I/Arith_R decode: ADD, SUB (R-type funct7[5] only), SLL, SLT, SLTU, XOR, SRL, SRA (funct7[5], also SRAI), OR, AND; LUI uses PASS; branches use SUB.
REQ-021 Carry the control bundle through the ID/EX, EX/MEM and MEM/WB registers, advancing one stage per cycle; latency from ID to the WB outputs is 3 cycles.
REQ-022 Insert a bubble (all strobes and enables 0, pc_sel 00) into ID/EX when id_valid=0, on an unknown opcode, on stall, or on flush.
REQ-023 Suppress write-back when rd=x0.
REQ-024 Load-use: when EX holds a load with rd≠0, and rd equals an rs1/rs2 actually read by the ID instruction, assert stall for exactly one cycle (state STALL) and bubble ID/EX.
REQ-025 Branch resolution in EX, combinational on the flags: BEQ zf; BNE !zf; BLT sf≠vf; BGE sf==vf; BLTU !cf; BGEU cf.
REQ-026 On a taken branch or JAL in EX, drive pc_sel=01; on JALR, drive pc_sel=10; in either case assert flush and bubble ID/EX in that cycle.
REQ-027 flush has priority over stall in the same cycle; stall is deasserted and the state returns to RUN.
REQ-028 States: RUN, STALL and HALT.
  - RUN→STALL on load-use; STALL→RUN after 1 cycle.
  - RUN→HALT when a non-flushed system instruction reaches EX and HALT_ON_SYSTEM=1.
REQ-029 In HALT: stall=1 and halted=1; ID/EX is bubbled; EX/MEM and MEM/WB drain normally. HALT exits only on reset.
REQ-030 A system instruction that is flushed before it reaches EX does not halt the core.

Reset
REQ-031 While rst_n=0: all pipeline control registers are bubbles, state=RUN, and every output is 0 (pc_sel=00, wb_src=00, wb_rd=0).
REQ-032 Reset asserted mid-stall, mid-flush or in HALT returns to RUN immediately, with no write or memory strobe emitted afterwards.

Structure
REQ-033 Shared package pipe_ctrl_pkg holds:
  - opcode, funct3 and ALU-code constants;
  - the RUN/STALL/HALT state type;
  - the control-bundle struct.
REQ-034 Combinational decode lives in one sub-module, ctrl_decode; pipe_ctrl holds the pipeline registers, hazard logic and FSM.

Verification
REQ-035 ADDI x1,x0,5 in ID at cycle 0 -> at cycle 3: wb_regwrite=1, wb_rd=1, wb_src=00; ALU code ADD was issued at cycle 1.
REQ-036 LW x2,0(x1) followed by ADD x3,x2,x2 -> stall=1 for exactly one cycle, one bubble in ID/EX, then ADD proceeds.
REQ-037 BEQ in EX with ex_zf=1 -> pc_sel=01 and flush=1 that cycle. With ex_zf=0 -> pc_sel=00, flush=0.
REQ-038 BLTU in EX with ex_cf=0 while a load-use stall is also detected -> flush=1, stall=0, state=RUN.
REQ-039 ECALL preceded by SW -> mem_write=1 for the SW, then halted=1 and stall held for 20+ cycles; rst_n pulse low -> all outputs 0, halted=0.
REQ-040 ADD x0,x1,x2 -> wb_regwrite=0 at cycle 3.
